handshake_rx: RTL and testbench

//  Destination endpoint of the 4-phase req/ack bundled-data CDC handshake. Lives entirely in clk.

---
 rtl/handshake_rx.sv | 154 +++++++++++++++
 tb/tb_handshake_rx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_rx.sv
// handshake_rx: receiving end of a 4-phase req/ack bundled-data crossing.
// The incoming req goes through a synchroniser. Each transfer captures one
// word into a small circular FIFO, and the FIFO is drained on a valid/ready
// stream. The sender is held off by keeping ack low while the FIFO is full.
module handshake_rx #(
  parameter int WIDTH       = 7,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_a,
  input  logic [WIDTH-1:0]         data_a,
  output logic                     ack,
  output logic [WIDTH-1:0]         data_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACKED = 1'b1
  } state_t;

  state_t                 state_r;
  logic                   ack_r;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   req_sync_s;

  logic [WIDTH-1:0]       mem_r [DEPTH];
  logic [PW-1:0]          wr_ptr_r;
  logic [PW-1:0]          rd_ptr_r;
  logic [CW-1:0]          count_r;
  logic                   valid_r;
  logic [WIDTH-1:0]       data_out_r;

  logic                   push_s;
  logic                   pop_s;
  logic [PW-1:0]          wr_ptr_nx_s;
  logic [PW-1:0]          rd_ptr_nx_s;
  logic [CW-1:0]          count_nx_s;
  logic [WIDTH-1:0]       head_nx_s;

  assign req_sync_s = sync_r[SYNC_STAGES-1];

  // Synchronise req_a; nothing else in the block looks at req_a.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], req_a};
    end
  end

  // Push/pop decisions and next FIFO pointers, occupancy and head word.
  always_comb begin
    push_s      = (state_r == IDLE) && req_sync_s && (count_r < DEPTH_C);
    pop_s       = valid_r && ready_in;
    wr_ptr_nx_s = wr_ptr_r;
    rd_ptr_nx_s = rd_ptr_r;
    count_nx_s  = count_r;
    head_nx_s   = data_out_r;
    if (push_s) begin
      wr_ptr_nx_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nx_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nx_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nx_s = rd_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   count_nx_s = count_r + CNT_ONE;
      2'b01:   count_nx_s = count_r - CNT_ONE;
      default: count_nx_s = count_r;
    endcase
    // The word being written becomes the head when it lands on the next read slot.
    if (push_s && (wr_ptr_r == rd_ptr_nx_s)) begin
      head_nx_s = data_a;
    end else begin
      head_nx_s = mem_r[rd_ptr_nx_s];
    end
  end

  // FIFO storage, pointers, occupancy and the registered stream outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      valid_r    <= 1'b0;
      data_out_r <= {WIDTH{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= data_a;
      end
      wr_ptr_r   <= wr_ptr_nx_s;
      rd_ptr_r   <= rd_ptr_nx_s;
      count_r    <= count_nx_s;
      valid_r    <= (count_nx_s != {CW{1'b0}});
      data_out_r <= head_nx_s;
    end
  end

  // Handshake FSM: ack rises with the capture and falls once req is seen low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      ack_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_sync_s && (count_r < DEPTH_C)) begin
            ack_r   <= 1'b1;
            state_r <= ACKED;
          end else begin
            ack_r   <= 1'b0;
            state_r <= IDLE;
          end
        end
        ACKED: begin
          if (!req_sync_s) begin
            ack_r   <= 1'b0;
            state_r <= IDLE;
          end else begin
            ack_r   <= 1'b1;
            state_r <= ACKED;
          end
        end
        default: begin
          ack_r   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign ack       = ack_r;
  assign data_out  = data_out_r;
  assign valid_out = valid_r;
  assign count     = count_r;

endmodule

// File: tb/tb_handshake_rx.sv
// Testbench for handshake_rx: a remote-sender model drives 4-phase transfers
// with random data. A reference stream (a queue of words sent, plus counts of
// words accepted and words popped) checks order, occupancy and stream rules.
module tb_handshake_rx;

  localparam int WIDTH = 7;
  localparam int SYNC  = 2;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req_a;
  logic [WIDTH-1:0] data_a;
  logic             ack;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             ready_in;
  logic [1:0]       count;

  always #5 clk = ~clk;

  handshake_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_a     (req_a),
    .data_a    (data_a),
    .ack       (ack),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .count     (count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference stream state
  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] exp_w;
  int               acc_n;
  int               pop_n;
  bit               mon_en = 1'b0;
  logic             ack_prev;
  logic             vprev;
  logic             rprev;
  logic [WIDTH-1:0] dprev;
  int               ready_mode = 0;

  // Stream monitor, sampling mid-cycle after the driver has updated inputs.
  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      if (ack && !ack_prev) acc_n++;
      check_eq("count", {30'd0, count}, acc_n - pop_n);
      check_eq("count_le_depth", {31'd0, (int'(count) <= DEPTH)}, 32'd1);
      check_eq("valid_vs_count", {31'd0, valid_out}, {31'd0, (count != 2'd0)});
      if (vprev && !rprev) begin
        check_eq("hold_valid", {31'd0, valid_out}, 32'd1);
        check_eq("hold_data", {25'd0, data_out}, {25'd0, dprev});
      end
      if (valid_out && ready_in) begin
        check_eq("pop_has_expected", {31'd0, (exp_q.size() != 0)}, 32'd1);
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          check_eq("data_order", {25'd0, data_out}, {25'd0, exp_w});
        end
        pop_n++;
      end
      ack_prev = ack;
      vprev    = valid_out;
      rprev    = ready_in;
      dprev    = data_out;
    end else begin
      acc_n    = 0;
      pop_n    = 0;
      ack_prev = ack;
      vprev    = 1'b0;
      rprev    = 1'b0;
      dprev    = data_out;
    end
  end

  task automatic tick();
    @(negedge clk);
    case (ready_mode)
      1:       ready_in = ~ready_in;
      2:       ready_in = 1'($urandom_range(0, 1));
      default: ;
    endcase
  endtask

  task automatic send_word(input logic [WIDTH-1:0] d);
    int n;
    repeat ($urandom_range(0, 3)) tick();
    tick();
    data_a = d;
    req_a  = 1'b1;
    exp_q.push_back(d);
    n = 0;
    while (!ack && n < 200) begin tick(); n++; end
    check_eq("ack_rise_timeout", {31'd0, ack}, 32'd1);
    req_a = 1'b0;
    n = 0;
    while (ack && n < 200) begin tick(); n++; end
    check_eq("ack_fall_timeout", {31'd0, ack}, 32'd0);
    data_a = 7'($urandom);
  endtask

  task automatic drain();
    int n;
    ready_mode = 0;
    ready_in   = 1'b1;
    n = 0;
    while (count != 2'd0 && n < 50) begin tick(); n++; end
    tick();
    check_eq("drain_count", {30'd0, count}, 32'd0);
    check_eq("drain_queue_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    int n;
    reset_n  = 1'b0;
    req_a    = 1'b1;
    data_a   = 7'h3C;
    ready_in = 1'b0;

    // 1: reset with req held high, then release
    repeat (3) tick();
    check_eq("rst_ack", {31'd0, ack}, 32'd0);
    check_eq("rst_valid", {31'd0, valid_out}, 32'd0);
    check_eq("rst_count", {30'd0, count}, 32'd0);
    reset_n = 1'b1;
    tick();
    check_eq("rel_ack_e1", {31'd0, ack}, 32'd0);
    tick();
    check_eq("rel_ack_e2", {31'd0, ack}, 32'd0);
    tick();
    check_eq("rel_ack_e3", {31'd0, ack}, 32'd1);
    check_eq("rel_valid", {31'd0, valid_out}, 32'd1);
    check_eq("rel_data", {25'd0, data_out}, 32'h3C);
    req_a = 1'b0;
    repeat (3) tick();
    check_eq("rel_ack_fall", {31'd0, ack}, 32'd0);
    ready_in = 1'b1;
    tick();
    check_eq("rel_popped_valid", {31'd0, valid_out}, 32'd0);
    check_eq("rel_popped_count", {30'd0, count}, 32'd0);
    exp_q.delete();
    mon_en = 1'b1;
    tick();

    // 2: single transfer, latency both ways
    tick();
    data_a = 7'h5A;
    req_a  = 1'b1;
    exp_q.push_back(7'h5A);
    n = 0;
    while (!ack && n < 20) begin tick(); n++; end
    check_eq("t2_ack_rise_latency", n, SYNC + 1);
    check_eq("t2_valid", {31'd0, valid_out}, 32'd1);
    check_eq("t2_data", {25'd0, data_out}, 32'h5A);
    tick();
    check_eq("t2_valid_one_cycle", {31'd0, valid_out}, 32'd0);
    req_a = 1'b0;
    n = 0;
    while (ack && n < 20) begin tick(); n++; end
    check_eq("t2_ack_fall_latency", n, SYNC + 1);

    // 3: backpressure holds off the third word
    ready_in = 1'b0;
    send_word(7'h11);
    send_word(7'h22);
    check_eq("t3_full", {30'd0, count}, 32'd2);
    tick();
    data_a = 7'h33;
    req_a  = 1'b1;
    exp_q.push_back(7'h33);
    repeat (8) begin
      tick();
      check_eq("t3_ack_held_off", {31'd0, ack}, 32'd0);
    end
    check_eq("t3_still_full", {30'd0, count}, 32'd2);
    ready_in = 1'b1;
    tick();
    check_eq("t3_count_after_pop", {30'd0, count}, 32'd1);
    check_eq("t3_ack_not_yet", {31'd0, ack}, 32'd0);
    tick();
    check_eq("t3_ack_rise", {31'd0, ack}, 32'd1);
    req_a = 1'b0;
    n = 0;
    while (ack && n < 20) begin tick(); n++; end
    check_eq("t3_ack_fall", {31'd0, ack}, 32'd0);
    drain();

    // 4: ready toggling every cycle, wrap and simultaneous push/pop
    ready_mode = 1;
    for (int i = 0; i < 10; i++) send_word(7'($urandom));
    drain();

    // 4b: random ready
    ready_mode = 2;
    for (int i = 0; i < 15; i++) send_word(7'($urandom));
    drain();

    // 5: async reset while ACKED with one word held
    ready_in = 1'b0;
    tick();
    mon_en = 1'b0;
    data_a = 7'h4D;
    req_a  = 1'b1;
    n = 0;
    while (!ack && n < 20) begin tick(); n++; end
    check_eq("t5_acked", {31'd0, ack}, 32'd1);
    check_eq("t5_count1", {30'd0, count}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t5_rst_ack", {31'd0, ack}, 32'd0);
    check_eq("t5_rst_valid", {31'd0, valid_out}, 32'd0);
    check_eq("t5_rst_count", {30'd0, count}, 32'd0);
    req_a = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    repeat (10) begin
      tick();
      check_eq("t5_no_stale_valid", {31'd0, valid_out}, 32'd0);
      check_eq("t5_no_stale_count", {30'd0, count}, 32'd0);
    end
    exp_q.delete();
    mon_en = 1'b1;
    tick();
    ready_in = 1'b1;
    send_word(7'h6E);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
